// File: rtl/decoder_pkg.sv
// Shared types and helpers for the decoder_scan block: FSM state encoding
// and the one-hot output width derived from the select width.
package decoder_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } decoder_state_t;

    function automatic int out_width(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/decoder_n_to_m.sv
// Purely combinational N-to-2^N one-hot decoder; all-zero output when disabled.
module decoder_n_to_m
    import decoder_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                    ena,
    input  logic [N-1:0]            in,
    output logic [out_width(N)-1:0] out
);

    always_comb begin
        out = '0;
        if (ena) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with a built-in scan sequencer (direct decode or
// a sweep of every output line). Define DECODER_SCAN_WRAP_EN for continuous scan.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int N     = 3,
    parameter int DWELL = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    mode,
    input  logic [N-1:0]            in,
    input  logic                    start,
    output logic [out_width(N)-1:0] out,
    output logic [N-1:0]            index,
    output logic                    busy,
    output logic                    done
);

    localparam int M  = out_width(N);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [N-1:0]  LAST_IDX = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

`ifdef DECODER_SCAN_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    if (DWELL < 1) begin : g_dwell_check
        $error("decoder_scan: DWELL must be >= 1");
    end

    decoder_state_t state_q, state_d;
    logic [N-1:0]   index_q, index_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [M-1:0]   out_q, out_d;
    logic           done_q, done_d;

    logic           dwell_end;
    logic           pass_end;
    logic           dec_ena;
    logic [N-1:0]   dec_in;
    logic [M-1:0]   dec_out;

    assign dwell_end = (cnt_q == CNT_LAST);
    assign pass_end  = (state_q == S_SCAN) && dwell_end && (index_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            index_q <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ena && mode && start) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                // An ena drop aborts even on the final dwell cycle.
                if (!ena) begin
                    state_d = S_IDLE;
                end else if (pass_end && !WRAP_EN) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        index_d = '0;
        cnt_d   = '0;
        if (state_d == S_SCAN && state_q == S_SCAN) begin
            if (dwell_end) begin
                // N-bit arithmetic wraps the last index back to 0 in wrap mode.
                index_d = index_q + N'(1);
            end else begin
                index_d = index_q;
                cnt_d   = cnt_q + CW'(1);
            end
        end
        done_d  = pass_end && ena;
        dec_in  = (state_d == S_SCAN) ? index_d : in;
        dec_ena = (state_d == S_SCAN) || (state_q == S_IDLE && ena && !mode);
        out_d   = dec_out;
    end

    decoder_n_to_m #(.N(N)) u_dec (
        .ena (dec_ena),
        .in  (dec_in),
        .out (dec_out)
    );

    assign out   = out_q;
    assign index = index_q;
    assign busy  = (state_q == S_SCAN);
    assign done  = done_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: four instances (N/DWELL sweep) share one
// stimulus bus; each step names the instance whose outputs are checked.
module tb_decoder_scan;

`ifdef DECODER_SCAN_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0;
  logic mode = 1'b0;
  logic start = 1'b0;
  logic [3:0] in_r = '0;

  logic [7:0] o0, o1;
  logic [2:0] x0, x1;
  logic [1:0] o2;
  logic [0:0] x2;
  logic [15:0] o3;
  logic [3:0] x3;
  logic b0, b1, b2, b3, d0, d1, d2, d3;

  int tests_run = 0;
  int tests_failed = 0;
  logic [23:0] exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  decoder_scan #(.N(3), .DWELL(2)) u0 (.clk(clk), .rst(rst), .ena(ena), .mode(mode),
    .in(in_r[2:0]), .start(start), .out(o0), .index(x0), .busy(b0), .done(d0));
  decoder_scan #(.N(3), .DWELL(1)) u1 (.clk(clk), .rst(rst), .ena(ena), .mode(mode),
    .in(in_r[2:0]), .start(start), .out(o1), .index(x1), .busy(b1), .done(d1));
  decoder_scan #(.N(1), .DWELL(1)) u2 (.clk(clk), .rst(rst), .ena(ena), .mode(mode),
    .in(in_r[0:0]), .start(start), .out(o2), .index(x2), .busy(b2), .done(d2));
  decoder_scan #(.N(4), .DWELL(3)) u3 (.clk(clk), .rst(rst), .ena(ena), .mode(mode),
    .in(in_r), .start(start), .out(o3), .index(x3), .busy(b3), .done(d3));

  function automatic logic [23:0] pack(input logic [1:0] id, input logic [15:0] o,
                                       input logic [3:0] x, input logic b, input logic d);
    return {id, o, x, b, d};
  endfunction

  // Drive one cycle of inputs on the falling edge; the response appears after the next rising edge.
  task automatic step(input logic [1:0] id, input logic r, input logic e, input logic m,
                      input logic [3:0] i, input logic s, input logic [15:0] eo,
                      input logic [3:0] ei, input logic eb, input logic ed, input string nm);
    @(negedge clk);
    rst = r;
    ena = e;
    mode = m;
    in_r = i;
    start = s;
    exp_q.push_back(pack(id, eo, ei, eb, ed));
    name_q.push_back(nm);
  endtask

  // Scan cycles 0..upto-1 after a start; cycle c shows index (c mod P)/dwell.
  task automatic scan_pass(input logic [1:0] id, input int n, input int dwell,
                           input int upto, input int restart_at, input string nm);
    int p;
    int k;
    logic [15:0] one16;
    one16 = 16'd1;
    p = (1 << n) * dwell;
    for (int c = 0; c < upto; c++) begin
      k = (c % p) / dwell;
      step(id, 1'b0, 1'b1, (c == 0) ? 1'b1 : 1'(c % 2), 4'($urandom_range(0, 15)),
           (c == 0) || (c == restart_at), one16 << k, 4'(k), 1'b1,
           (c > 0) && (c % p == 0), nm);
    end
  endtask

  task automatic finish_pass(input logic [1:0] id, input string nm);
    if (WRAP) begin
      step(id, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0001, 4'd0, 1'b1, 1'b1, nm);
      step(id, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, "wrap_exit");
    end else begin
      step(id, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b1, nm);
      step(id, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, "post_done");
    end
  endtask

  initial begin : monitor
    logic [23:0] e;
    logic [23:0] act;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        case (e[23:22])
          2'd0: act = pack(2'd0, 16'(o0), 4'(x0), b0, d0);
          2'd1: act = pack(2'd1, 16'(o1), 4'(x1), b1, d1);
          2'd2: act = pack(2'd2, 16'(o2), 4'(x2), b2, d2);
          default: act = pack(2'd3, o3, x3, b3, d3);
        endcase
        tests_run++;
        if (act !== e) begin
          tests_failed++;
          $display("FAIL %s (dut %0d): got out=%h index=%0d busy=%b done=%b, expected out=%h index=%0d busy=%b done=%b",
                   nm, e[23:22], act[21:6], act[5:2], act[1], act[0], e[21:6], e[5:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin : driver
    // Reset and direct decode
    step(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, "reset");
    step(2'd0, 1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0, "reset_priority");
    step(2'd0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 16'h0020, 4'd0, 1'b0, 1'b0, "direct_in5");
    step(2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0001, 4'd0, 1'b0, 1'b0, "direct_in0");
    step(2'd0, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 16'h0080, 4'd0, 1'b0, 1'b0, "direct_in7");
    step(2'd0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1, 16'h0004, 4'd0, 1'b0, 1'b0, "start_in_direct");
    step(2'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, "ena_low");
    step(2'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, "mode1_no_start");

    // Full pass with a second start at cycle 5
    scan_pass(2'd0, 3, 2, 16, 5, "full_pass");
    finish_pass(2'd0, "full_pass_done");

    // Abort while index=3
    scan_pass(2'd0, 3, 2, 7, -1, "abort_pre");
    step(2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0, "abort");
    step(2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, "abort_no_done");

    // ena drop on the final dwell cycle
    scan_pass(2'd0, 3, 2, 16, -1, "last_dwell_pre");
    step(2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, "last_dwell_abort");
    step(2'd0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 16'h0008, 4'd0, 1'b0, 1'b0, "after_abort_direct");

    // rst at index=6
    scan_pass(2'd0, 3, 2, 13, -1, "rst_pre");
    step(2'd0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0, "rst_mid_scan");
    step(2'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, "rst_idle");

    // N=3, DWELL=1: two passes when wrapping, one otherwise
    step(2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, "reset_d1");
    scan_pass(2'd1, 3, 1, WRAP ? 16 : 8, -1, "dwell1_pass");
    finish_pass(2'd1, "dwell1_done");

    // N=1, DWELL=1
    step(2'd2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, "reset_n1");
    step(2'd2, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 16'h0002, 4'd0, 1'b0, 1'b0, "n1_direct");
    step(2'd2, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, "n1_idle");
    scan_pass(2'd2, 1, 1, 2, -1, "n1_pass");
    finish_pass(2'd2, "n1_done");

    // N=4, DWELL=3: 48-cycle pass
    step(2'd3, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, "reset_n4");
    step(2'd3, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 16'h8000, 4'd0, 1'b0, 1'b0, "n4_direct");
    step(2'd3, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, "n4_idle");
    scan_pass(2'd3, 4, 3, 48, -1, "n4_pass");
    finish_pass(2'd3, "n4_done");

    // Bounded drain of the scoreboard
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
